// File: rtl/wupr_multibank_tracker_if.sv
// Scheduler <-> tracker bus for wupr_multibank_tracker: write snoop, refresh request,
// flush pulse, refresh decision and status outputs.
interface wupr_multibank_tracker_if #(
    parameter int ROW_WIDTH = 16,
    parameter int NUM_BANKS = 4,
    parameter int CNT_W     = 16
);
    localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic                 wr_valid;
    logic [BANK_BITS-1:0] wr_bank;
    logic [ROW_WIDTH-1:0] wr_row;
    logic                 ref_valid;
    logic                 ref_ready;
    logic [BANK_BITS-1:0] ref_bank;
    logic [ROW_WIDTH-1:0] ref_row;
    logic                 flush_req;
    logic                 dref_valid;
    logic                 dref;
    logic [BANK_BITS-1:0] dref_bank;
    logic [ROW_WIDTH-1:0] dref_row;
    logic [CNT_W-1:0]     skip_cnt;
    logic                 clk_enable;

    modport master (
        output wr_valid, wr_bank, wr_row, ref_valid, ref_bank, ref_row, flush_req,
        input  ref_ready, dref_valid, dref, dref_bank, dref_row, skip_cnt, clk_enable
    );

    modport slave (
        input  wr_valid, wr_bank, wr_row, ref_valid, ref_bank, ref_row, flush_req,
        output ref_ready, dref_valid, dref, dref_bank, dref_row, skip_cnt, clk_enable
    );
endinterface

// File: rtl/wupr_multibank_tracker.sv
// Multi-bank write-update partial-refresh tracker: skips refreshes of row groups written since
// their last refresh. Optional per-group consecutive-skip limit under `WUPR_SKIP_LIMIT_EN.
module wupr_multibank_tracker #(
    parameter int ROW_WIDTH = 16,
    parameter int NUM_BANKS = 4,
    parameter int GRP_BITS  = 4,
    parameter int CNT_W     = 16,
    parameter int MAX_SKIP  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    wupr_multibank_tracker_if.slave bus
);
    localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int NUM_GRPS  = 2 ** GRP_BITS;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]                         state_q, state_d;
    logic [BANK_BITS-1:0]               ptr_q, ptr_d;
    logic [NUM_BANKS-1:0][NUM_GRPS-1:0] flags_q, flags_d;
    logic                               dref_valid_q, dref_valid_d;
    logic                               dref_q, dref_d;
    logic [BANK_BITS-1:0]               dref_bank_q, dref_bank_d;
    logic [ROW_WIDTH-1:0]               dref_row_q, dref_row_d;
    logic [CNT_W-1:0]                   skip_cnt_q, skip_cnt_d;

    logic                ref_fire;
    logic                ref_hit;
    logic                limit_hit;
    logic                wr_in_range;
    logic                ref_in_range;
    logic [GRP_BITS-1:0] wr_grp;
    logic [GRP_BITS-1:0] ref_grp;

    assign wr_grp       = bus.wr_row[ROW_WIDTH-1 -: GRP_BITS];
    assign ref_grp      = bus.ref_row[ROW_WIDTH-1 -: GRP_BITS];
    assign wr_in_range  = ({1'b0, bus.wr_bank} < (BANK_BITS+1)'(NUM_BANKS));
    assign ref_in_range = ({1'b0, bus.ref_bank} < (BANK_BITS+1)'(NUM_BANKS));
    assign ref_fire     = bus.ref_valid && (state_q == ST_IDLE);
    assign ref_hit      = ref_in_range && flags_q[bus.ref_bank][ref_grp];

`ifdef WUPR_SKIP_LIMIT_EN
    localparam int SL_W = (MAX_SKIP > 0) ? $clog2(MAX_SKIP + 1) : 1;

    logic [NUM_BANKS-1:0][NUM_GRPS-1:0][SL_W-1:0] sctr_q, sctr_d;

    // A skip that would push the group past MAX_SKIP consecutive skips becomes a real refresh.
    assign limit_hit = ref_hit && (sctr_q[bus.ref_bank][ref_grp] == SL_W'(MAX_SKIP));

    always_comb begin
        sctr_d = sctr_q;
        if (ref_fire && ref_in_range) begin
            if (ref_hit && !limit_hit)
                sctr_d[bus.ref_bank][ref_grp] = sctr_q[bus.ref_bank][ref_grp] + SL_W'(1);
            else
                sctr_d[bus.ref_bank][ref_grp] = '0;
        end
        if (state_q == ST_FLUSH)
            sctr_d[ptr_q] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sctr_q <= '0;
        else        sctr_q <= sctr_d;
    end
`else
    logic unused_max_skip;

    assign limit_hit       = 1'b0;
    assign unused_max_skip = (MAX_SKIP != 0);
`endif

    // Order matters: refresh/flush clears first, then a same-cycle write sets and wins.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        flags_d      = flags_q;
        dref_valid_d = 1'b0;
        dref_d       = dref_q;
        dref_bank_d  = dref_bank_q;
        dref_row_d   = dref_row_q;
        skip_cnt_d   = skip_cnt_q;

        if (ref_fire) begin
            dref_valid_d = 1'b1;
            dref_bank_d  = bus.ref_bank;
            dref_row_d   = bus.ref_row;
            dref_d       = !ref_hit || limit_hit;
            if (ref_hit) begin
                flags_d[bus.ref_bank][ref_grp] = 1'b0;
                if (!limit_hit && (skip_cnt_q != '1))
                    skip_cnt_d = skip_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.flush_req) begin
                    state_d = ST_FLUSH;
                    ptr_d   = '0;
                end
            end
            default: begin
                flags_d[ptr_q] = '0;
                if (ptr_q == BANK_BITS'(NUM_BANKS - 1))
                    state_d = ST_IDLE;
                else
                    ptr_d = ptr_q + BANK_BITS'(1);
            end
        endcase

        if (bus.wr_valid && wr_in_range)
            flags_d[bus.wr_bank][wr_grp] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            flags_q      <= '0;
            dref_valid_q <= 1'b0;
            dref_q       <= 1'b0;
            dref_bank_q  <= '0;
            dref_row_q   <= '0;
            skip_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            flags_q      <= flags_d;
            dref_valid_q <= dref_valid_d;
            dref_q       <= dref_d;
            dref_bank_q  <= dref_bank_d;
            dref_row_q   <= dref_row_d;
            skip_cnt_q   <= skip_cnt_d;
        end
    end

    assign bus.ref_ready  = (state_q == ST_IDLE);
    assign bus.dref_valid = dref_valid_q;
    assign bus.dref       = dref_q;
    assign bus.dref_bank  = dref_bank_q;
    assign bus.dref_row   = dref_row_q;
    assign bus.skip_cnt   = skip_cnt_q;
    assign bus.clk_enable = bus.wr_valid | bus.ref_valid | bus.flush_req | dref_valid_q
                          | (state_q != ST_IDLE);
endmodule

// File: tb/tb_wupr_multibank_tracker.sv
// Directed self-checking bench for wupr_multibank_tracker (default build or with
// WUPR_SKIP_LIMIT_EN); expected values are hand-computed.
module tb_wupr_multibank_tracker;
    localparam int ROW_WIDTH = 16;
    localparam int NUM_BANKS = 4;
    localparam int GRP_BITS  = 4;
    localparam int CNT_W     = 16;
    localparam int MAX_SKIP  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   expSkip = 0;
    int   lowCycles;

    wupr_multibank_tracker_if #(.ROW_WIDTH(ROW_WIDTH), .NUM_BANKS(NUM_BANKS), .CNT_W(CNT_W)) bus ();

    wupr_multibank_tracker #(
        .ROW_WIDTH(ROW_WIDTH), .NUM_BANKS(NUM_BANKS), .GRP_BITS(GRP_BITS),
        .CNT_W(CNT_W), .MAX_SKIP(MAX_SKIP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drives one cycle of inputs, returns 1 time unit after the sampling edge.
    task automatic applyStimulus(input logic wv, input logic [1:0] wb, input logic [15:0] wr,
                                 input logic rv, input logic [1:0] rb, input logic [15:0] rr,
                                 input logic fl);
        bus.wr_valid  = wv;
        bus.wr_bank   = wb;
        bus.wr_row    = wr;
        bus.ref_valid = rv;
        bus.ref_bank  = rb;
        bus.ref_row   = rr;
        bus.flush_req = fl;
        @(posedge clk);
        #1;
        bus.wr_valid  = 1'b0;
        bus.ref_valid = 1'b0;
        bus.flush_req = 1'b0;
    endtask

    task automatic doIdle();
        applyStimulus(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);
    endtask

    task automatic doWrite(input logic [1:0] b, input logic [15:0] row);
        applyStimulus(1'b1, b, row, 1'b0, 2'd0, 16'h0, 1'b0);
    endtask

    task automatic waitFlushDone(input string tag, input int expLow);
        lowCycles = 0;
        for (int i = 0; i < 20 && bus.ref_ready !== 1'b1; i++) begin
            lowCycles++;
            doIdle();
        end
        checkOutput(tag, lowCycles, expLow);
    endtask

    // Issues a refresh and checks the registered decision on the following edge.
    task automatic refCheck(input string tag, input logic [1:0] b, input logic [15:0] row,
                            input logic expDref);
        applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, b, row, 1'b0);
        if (!expDref) expSkip++;
        checkOutput({tag, "_valid"}, bus.dref_valid, 1);
        checkOutput({tag, "_dref"}, bus.dref, expDref);
        checkOutput({tag, "_bank"}, bus.dref_bank, b);
        checkOutput({tag, "_row"}, bus.dref_row, row);
        checkOutput({tag, "_skip"}, bus.skip_cnt, expSkip);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.wr_valid  = 1'b0;
        bus.wr_bank   = '0;
        bus.wr_row    = '0;
        bus.ref_valid = 1'b0;
        bus.ref_bank  = '0;
        bus.ref_row   = '0;
        bus.flush_req = 1'b0;
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;

        checkOutput("rst_dref_valid", bus.dref_valid, 0);
        checkOutput("rst_skip_cnt", bus.skip_cnt, 0);
        checkOutput("rst_ref_ready", bus.ref_ready, 1);
        checkOutput("rst_clk_enable", bus.clk_enable, 0);

        doWrite(2'd1, 16'h3ABC);
        refCheck("skip_b1", 2'd1, 16'h3000, 1'b0);
        checkOutput("pulse_clken", bus.clk_enable, 1);
        doIdle();
        checkOutput("pulse_end", bus.dref_valid, 0);
        refCheck("reref_b1", 2'd1, 16'h3000, 1'b1);

        refCheck("fresh_b2", 2'd2, 16'h3000, 1'b1);

        applyStimulus(1'b1, 2'd0, 16'h5000, 1'b1, 2'd0, 16'h5123, 1'b0);
        checkOutput("samecyc_dref", bus.dref, 1);
        checkOutput("samecyc_valid", bus.dref_valid, 1);
        refCheck("after_samecyc", 2'd0, 16'h5000, 1'b0);

        for (int b = 0; b < 4; b++) doWrite(2'(b), 16'((b + 1) << 12));
        applyStimulus(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b1);
        checkOutput("flush_clken", bus.clk_enable, 1);
        waitFlushDone("flush_len", 4);
        for (int b = 0; b < 4; b++) refCheck("post_flush", 2'(b), 16'((b + 1) << 12), 1'b1);

        applyStimulus(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b1);
        doWrite(2'd0, 16'h9000);
        doWrite(2'd3, 16'h9000);
        waitFlushDone("flush2_len", 2);
        refCheck("retain_b0", 2'd0, 16'h9000, 1'b0);
        refCheck("cleared_b3", 2'd3, 16'h9000, 1'b1);

        for (int i = 0; i < 3; i++) begin
            doWrite(2'd0, 16'h7000);
`ifdef WUPR_SKIP_LIMIT_EN
            refCheck("limit", 2'd0, 16'h7000, (i == 2));
`else
            refCheck("limit", 2'd0, 16'h7000, 1'b0);
`endif
        end

        doWrite(2'd1, 16'hA000);
        refCheck("pre_reset", 2'd2, 16'h1000, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", bus.dref_valid, 0);
        checkOutput("midrst_dref", bus.dref, 0);
        checkOutput("midrst_skip", bus.skip_cnt, 0);
        checkOutput("midrst_ready", bus.ref_ready, 1);
        #2 rst_n = 1'b1;
        expSkip = 0;
        @(posedge clk);
        #1;
        refCheck("post_reset_b1", 2'd1, 16'hA000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
